// File: rtl/mul_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_seq_pkg;

  localparam int unsigned WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_if.sv
// Request/result bundle between a multiply requester and mul_seq.
interface mul_seq_if #(
  parameter int unsigned WIDTH = mul_seq_pkg::WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/mul_seq_add.sv
// Existing 8-bit ripple-carry adder; E=1 floats the sum and carry outputs.
module add (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       C0,
  input  logic       E,
  output logic [7:0] S,
  output logic       C8
);

  logic [8:0] c;
  logic [7:0] sum;

  // Bitwise ripple chain from C0 through bit 7.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = C0;
    for (int unsigned i = 0; i < 8; i++) begin
      sum[i]  = A[i] ^ B[i] ^ c[i];
      c[i+1]  = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
  end

  assign S  = E ? 'z   : sum;
  assign C8 = E ? 1'bz : c[8];

endmodule

// File: rtl/mul_seq.sv
// Sequential unsigned multiplier: one add-then-shift step per RUN cycle.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = mul_seq_pkg::WIDTH
) (
  input  logic     clk,
  input  logic     rst,
  mul_seq_if.slave bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] acc;
  logic [2:0]       cnt;

  logic             add_e;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_s;
  logic             add_c8;

  add u_add (
    .A  (acc),
    .B  (add_b),
    .C0 (1'b0),
    .E  (add_e),
    .S  (add_s),
    .C8 (add_c8)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: 8 RUN cycles, a single DONE cycle, start only seen in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)     state_nxt = RUN;
      RUN:     if (cnt == 3'd7)   state_nxt = DONE;
      DONE:                       state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Outputs and adder controls; the adder is enabled only in RUN and never under reset.
  always_comb begin
    bus.busy = (state == RUN) || (state == DONE);
    bus.done = (state == DONE);
    bus.p    = {acc, mq};
    add_e    = rst || (state != RUN);
    add_b    = mq[0] ? mcand : '0;
  end

  // Datapath: capture operands on accepted start, then {acc,mq} <= {C8,S,mq[7:1]} per RUN edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      mq    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            mcand <= bus.a;
            mq    <= bus.b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc <= {add_c8, add_s[WIDTH-1:1]};
          mq  <= {add_s[0], mq[WIDTH-1:1]};
          cnt <= cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq against a plain a*b reference.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mul_seq_if #(.WIDTH(8)) bus ();

  mul_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    int unsigned r;
    r = int'(x) * int'(y);
    return r[15:0];
  endfunction

  // mode 0: plain, 1: scramble a/b during RUN, 2: extra start in RUN cycle 3
  task automatic run_mul(input logic [7:0] ta, input logic [7:0] tb, input int mode);
    int lat;
    int busyc;
    int dones;
    logic [15:0] exp_p;
    exp_p = ref_mul(ta, tb);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b = tb;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1; busyc = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) busyc++;
      chk("e_run", dut.add_e, 32'd0);
      chk("s_known", 32'($isunknown(dut.add_s)), 32'd0);
      if (mode == 1) begin bus.a = 8'($urandom); bus.b = 8'($urandom); end
      if (mode == 2 && lat == 3) begin
        bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd9;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    if (bus.busy) busyc++;
    chk("latency", 32'(lat), 32'd9);
    chk("busy_cycles", 32'(busyc), 32'd9);
    chk("product", 32'(bus.p), 32'(exp_p));
    chk("e_done", dut.add_e, 32'd1);
    @(negedge clk);
    chk("done_pulse", bus.done, 32'd0);
    chk("busy_idle", bus.busy, 32'd0);
    chk("e_idle", dut.add_e, 32'd1);
    chk("p_hold", 32'(bus.p), 32'(exp_p));
    dones = 0;
    repeat (3) begin
      bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(negedge clk);
      if (bus.done) dones++;
      chk("p_hold_idle", 32'(bus.p), 32'(exp_p));
    end
    chk("no_extra_done", 32'(dones), 32'd0);
  endtask

  task automatic reset_mid_run();
    int dones;
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'd3; bus.b = 8'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_pre_rst", bus.busy, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_done", bus.done, 32'd0);
    chk("rst_p", 32'(bus.p), 32'd0);
    chk("rst_e", dut.add_e, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("rst_no_done", 32'(dones), 32'd0);
    run_mul(8'd2, 8'd7, 0);
  endtask

  task automatic back_to_back(input int n);
    logic [7:0] ca;
    logic [7:0] cb;
    int cyc;
    int last;
    int w;
    ca = 8'($urandom); cb = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b1; bus.a = ca; bus.b = cb;
    cyc = 0; last = 0;
    for (int k = 0; k < n; k++) begin
      w = 0;
      @(negedge clk); cyc++;
      while (!bus.done && w < 30) begin
        @(negedge clk); cyc++; w++;
      end
      chk("b2b_p", 32'(bus.p), 32'(ref_mul(ca, cb)));
      if (k > 0) chk("b2b_period", 32'(cyc - last), 32'd10);
      last = cyc;
      ca = 8'($urandom); cb = 8'($urandom);
      bus.a = ca; bus.b = cb;
      @(negedge clk); cyc++;
      chk("b2b_pulse", bus.done, 32'd0);
      if (k == n - 1) bus.start = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("b2b_quiet", bus.busy, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    #12;
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_done", bus.done, 32'd0);
    chk("reset_p", 32'(bus.p), 32'd0);
    chk("reset_e", dut.add_e, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", bus.busy, 32'd0);
    chk("idle_e", dut.add_e, 32'd1);

    run_mul(8'h0D, 8'h0B, 0);
    run_mul(8'hFF, 8'hFF, 1);
    run_mul(8'h00, 8'hA5, 0);
    run_mul(8'h01, 8'h80, 1);
    run_mul(8'd3, 8'd4, 2);
    reset_mid_run();
    for (int i = 0; i < 12; i++) run_mul(8'($urandom), 8'($urandom), i % 2);
    back_to_back(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
